// File: rtl/alu_result_display_pkg.sv
// Shared types and seven-segment constants for the ALU result display.
package alu_disp_pkg;

    typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, DONE} disp_state_t;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9.
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        pat = SEG_BLANK;
        if (nib <= 4'd9) pat = SEG_LUT[nib];
        return pat;
    endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// Bundle between the ALU result producer and the display block.
// Handshake: none; answer is a level sampled whenever the converter is idle, busy/bcd_valid are status levels.
interface alu_result_display_if #(
    parameter int num_width  = 8,
    parameter int NUM_DIGITS = 3
);
    import alu_disp_pkg::*;

    logic [num_width-1:0]  answer;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;
    logic                  busy;
    logic                  bcd_valid;
    disp_state_t           state;

    modport master (output answer, input seg, an, busy, bcd_valid, state);
    modport slave  (input answer, output seg, an, busy, bcd_valid, state);

endinterface

// File: rtl/alu_result_display_bin2bcd_seq.sv
// Sequential double-dabble converter; re-converts whenever the input differs from the last capture.
module bin2bcd_seq
    import alu_disp_pkg::*;
#(
    parameter int num_width  = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [num_width-1:0]    bin,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    busy,
    output logic                    valid,
    output disp_state_t             state
);
    localparam int BW   = 4 * NUM_DIGITS;
    localparam int CNTW = $clog2(num_width + 1);

    logic [num_width-1:0] captured;
    logic [num_width-1:0] bin_sh;
    logic [BW-1:0]        accum;
    logic [CNTW-1:0]      count;

    function automatic logic [BW-1:0] adjust(input logic [BW-1:0] a);
        logic [BW-1:0] r;
        r = a;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            captured <= '0;
            bin_sh   <= '0;
            accum    <= '0;
            count    <= '0;
            bcd      <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!valid || bin != captured) begin
                        captured <= bin;
                        bin_sh   <= bin;
                        accum    <= '0;
                        count    <= CNTW'(num_width);
                        busy     <= 1'b1;
                        state    <= ADJUST;
                    end
                end
                ADJUST: begin
                    accum <= adjust(accum);
                    state <= SHIFT;
                end
                SHIFT: begin
                    {accum, bin_sh} <= {accum[BW-2:0], bin_sh, 1'b0};
                    count           <= count - 1'b1;
                    state           <= (count == CNTW'(1)) ? DONE : ADJUST;
                end
                DONE: begin
                    // Shown value only moves here, so the display never sees a partial result.
                    bcd   <= accum;
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// ALU result display: BCD conversion plus multiplexed common-anode seven-segment scan.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int num_width   = 8,
    parameter int NUM_DIGITS  = 3,
    parameter int REFRESH_DIV = 100000
) (
    input logic                 clk,
    input logic                 reset,
    alu_result_display_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] shown;
    logic                    conv_busy;
    logic                    conv_valid;
    disp_state_t             conv_state;

    logic [CW-1:0]           refresh_cnt;
    logic [DW-1:0]           digit_idx;
    logic [NUM_DIGITS-1:0]   lit;
    logic                    nz;
    logic [3:0]              cur_nib;
    logic                    cur_lit;
    logic [NUM_DIGITS-1:0]   next_an;
    logic [6:0]              next_seg;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;

    bin2bcd_seq #(
        .num_width  (num_width),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .bin   (bus.answer),
        .bcd   (shown),
        .busy  (conv_busy),
        .valid (conv_valid),
        .state (conv_state)
    );

    // A digit is lit if it or any more significant digit is non-zero; units always lit.
    always_comb begin
        nz      = 1'b0;
        lit     = '0;
        cur_nib = '0;
        cur_lit = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nz     = nz | (|shown[4*k +: 4]);
            lit[k] = nz || (k == 0);
            if (digit_idx == DW'(k)) begin
                cur_nib = shown[4*k +: 4];
                cur_lit = lit[k];
            end
        end
        next_an  = '1;
        next_seg = SEG_BLANK;
        if (conv_valid && cur_lit) begin
            next_an  = ~(NUM_DIGITS'(1) << digit_idx);
            next_seg = seg_decode(cur_nib);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
        end else begin
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an_q  <= next_an;
            seg_q <= next_seg;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.busy      = conv_busy;
    assign bus.bcd_valid = conv_valid;
    assign bus.state     = conv_state;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display with a decimal-arithmetic display model.
module tb_alu_result_display;

    localparam int R = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_result_display_if #(.num_width(8), .NUM_DIGITS(3)) bus ();

    alu_result_display #(
        .num_width   (8),
        .NUM_DIGITS  (3),
        .REFRESH_DIV (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_edges  = 0;
    int scan_busy = 0;
    bit mon_en = 1'b0;
    int allowed[$];

    // Rising edges since reset release; the scan position follows from this alone.
    always @(posedge clk or negedge reset) begin
        if (!reset) n_edges = 0;
        else        n_edges = n_edges + 1;
    end

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] ref_pattern(input int dv);
        case (dv)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic bit is_lit(input int v, input int d);
        return (d == 0) || (v >= pow10(d));
    endfunction

    function automatic logic [2:0] exp_an(input int v, input int d);
        logic [2:0] one_hot;
        one_hot = 3'b001 << d;
        return is_lit(v, d) ? ~one_hot : 3'b111;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int d);
        return is_lit(v, d) ? ref_pattern((v / pow10(d)) % 10) : 7'h7F;
    endfunction

    function automatic int cur_digit();
        return ((n_edges - 1) / R) % 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scan(input int v, input int cycles);
        int d;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            d = cur_digit();
            check("scan_an", 32'(bus.an), 32'(exp_an(v, d)));
            check("scan_seg", 32'(bus.seg), 32'(exp_seg(v, d)));
            if (bus.busy) scan_busy++;
        end
    endtask

    task automatic wait_conv(input string tag, input bit blank);
        int t;
        int cnt;
        t = 0;
        while (!bus.busy && t < 5) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start"}, 32'(bus.busy), 32'd1);
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            if (blank) check({tag, "_blank"}, 32'(bus.an), 32'h7);
            cnt++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(cnt), 32'd17);
        check({tag, "_valid"}, 32'(bus.bcd_valid), 32'd1);
    endtask

    // Any lit digit must belong to one of the whole values legitimately on display.
    always @(negedge clk) begin
        if (mon_en && reset) begin
            bit found;
            int d;
            found = 1'b0;
            d = cur_digit();
            foreach (allowed[i]) begin
                if (bus.an === exp_an(allowed[i], d) && bus.seg === exp_seg(allowed[i], d))
                    found = 1'b1;
            end
            check("no_tear", 32'(found), 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        int last;
        int k;
        int cnt;

        bus.answer = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_an", 32'(bus.an), 32'h7);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.bcd_valid), 32'd0);

        // First conversion after reset, display blanked until it lands.
        reset = 1'b1;
        wait_conv("zero", 1'b1);
        scan(0, 6 * R);

        bus.answer = 8'd255;
        wait_conv("c255", 1'b0);
        scan(255, 6 * R);

        bus.answer = 8'd7;
        wait_conv("c7", 1'b0);
        scan(7, 6 * R);

        // Input changes mid-conversion: 100 completes, then 42 follows.
        allowed = '{7, 100, 42};
        mon_en = 1'b1;
        bus.answer = 8'd100;
        @(negedge clk);
        check("c100_start", 32'(bus.busy), 32'd1);
        cnt = 1;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy) cnt++;
        end
        bus.answer = 8'd42;
        while (bus.busy && cnt < 100) begin
            @(negedge clk);
            if (bus.busy) cnt++;
        end
        check("c100_latency", 32'(cnt), 32'd17);
        k = 0;
        scan(100, 12);
        k = 12;
        while (bus.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("c42_follow", 32'(k), 32'd18);
        mon_en = 1'b0;
        scan(42, 6 * R);

        // Held input: no further conversions, scan keeps rotating.
        scan_busy = 0;
        scan(42, 1000);
        check("hold_busy", 32'(scan_busy), 32'd0);

        last = 42;
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 255));
            if (v == last) v = (v + 1) % 256;
            bus.answer = 8'(v);
            wait_conv("rand", 1'b0);
            scan(v, 3 * R);
            last = v;
        end

        // Reset in the middle of a conversion.
        bus.answer = 8'(last == 200 ? 201 : 200);
        v = int'(bus.answer);
        @(negedge clk);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_seg", 32'(bus.seg), 32'h7F);
        check("mid_rst_an", 32'(bus.an), 32'h7);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_valid", 32'(bus.bcd_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_conv("post_rst", 1'b1);
        scan(v, 6 * R);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
